// File: rtl/program_counter_pkg.sv
// Shared PC-select encoding and default datapath width for the control unit and the PC.
package program_counter_pkg;

    localparam int unsigned PC_WIDTH = 64;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_LOAD = 2'b10;
    localparam logic [1:0] PS_REL  = 2'b11;

endpackage

// File: rtl/program_counter_adder.sv
// WIDTH-bit modulo adder; the carry out is discarded.
module program_counter_adder #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/program_counter.sv
// Program counter: hold, increment, absolute load or PC-relative branch each rising edge.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int unsigned       WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       INCR        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       PS,
    input  logic [WIDTH-1:0] PC_IN,
    output logic [WIDTH-1:0] PC_OUT,
    output logic [WIDTH-1:0] PC4
);

    localparam logic [WIDTH-1:0] IncrW = WIDTH'(INCR);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_rel;

    program_counter_adder #(
        .WIDTH(WIDTH)
    ) u_inc_adder (
        .a  (pc_q),
        .b  (IncrW),
        .sum(PC4)
    );

    // Branch offset is relative to the current PC, not PC+4.
    program_counter_adder #(
        .WIDTH(WIDTH)
    ) u_rel_adder (
        .a  (pc_q),
        .b  (PC_IN),
        .sum(pc_rel)
    );

    always_comb begin
        pc_d = pc_q;
        case (PS)
            PS_HOLD: pc_d = pc_q;
            PS_INC:  pc_d = PC4;
            PS_LOAD: pc_d = PC_IN;
            PS_REL:  pc_d = pc_rel;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC_OUT = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench: driver queues expected PC/PC4, monitor pops and compares after each event.
module tb_program_counter;

    logic        clk;
    logic        rst;
    logic [1:0]  PS;
    logic [63:0] PC_IN;
    logic [63:0] PC_OUT;
    logic [63:0] PC4;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] pc4;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    event chk;

    program_counter dut (
        .clk   (clk),
        .rst   (rst),
        .PS    (PS),
        .PC_IN (PC_IN),
        .PC_OUT(PC_OUT),
        .PC4   (PC4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; expectation is for PC after the next rising edge.
    task automatic step(input logic [1:0] ps, input logic [63:0] in, input logic r,
                        input logic [63:0] e_pc, input logic [63:0] e_pc4, input string name);
        exp_t e;
        @(negedge clk);
        PS    = ps;
        PC_IN = in;
        rst   = r;
        e.pc  = e_pc;
        e.pc4 = e_pc4;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Raise rst between edges and check that PC clears before the next rising edge.
    task automatic async_reset(input logic [1:0] ps, input string name);
        exp_t e;
        @(negedge clk);
        PS = ps;
        #2;
        rst   = 1'b1;
        e.pc  = 64'h0;
        e.pc4 = 64'h4;
        e.name = name;
        exp_q.push_back(e);
        -> chk;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or chk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (PC_OUT !== e.pc) begin
                    failures++;
                    $display("FAIL %s PC_OUT got=%h expected=%h", e.name, PC_OUT, e.pc);
                end
                checks++;
                if (PC4 !== e.pc4) begin
                    failures++;
                    $display("FAIL %s PC4 got=%h expected=%h", e.name, PC4, e.pc4);
                end
            end
        end
    end

    initial begin : driver
        rst   = 1'b0;
        PS    = 2'b00;
        PC_IN = 64'h0;
        repeat (2) @(posedge clk);

        async_reset(2'b01, "reset_async");
        step(2'b00, 64'h0,  1'b0, 64'h0, 64'h4, "hold0");
        step(2'b00, 64'h55, 1'b0, 64'h0, 64'h4, "hold1");
        step(2'b00, 64'h0,  1'b0, 64'h0, 64'h4, "hold2");

        step(2'b01, 64'h0, 1'b0, 64'h4,  64'h8,  "inc4");
        step(2'b01, 64'h0, 1'b0, 64'h8,  64'hC,  "inc8");
        step(2'b01, 64'h0, 1'b0, 64'hC,  64'h10, "inc12");

        step(2'b10, 64'h10, 1'b0, 64'h10, 64'h14, "load16");
        step(2'b10, 64'h4,  1'b0, 64'h4,  64'h8,  "load4_back");

        step(2'b11, 64'h20,                  1'b0, 64'h24, 64'h28, "rel_plus32");
        step(2'b11, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h1C, 64'h20, "rel_minus8");
        step(2'b11, 64'h8,                   1'b0, 64'h24, 64'h28, "rel_plus8");

        async_reset(2'b01, "reset_prio");
        step(2'b01, 64'h0,   1'b1, 64'h0, 64'h4, "rst_held_inc");
        step(2'b10, 64'h100, 1'b1, 64'h0, 64'h4, "rst_held_load");
        step(2'b01, 64'h0,   1'b0, 64'h4, 64'h8, "rst_release_inc");

        step(2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, "load_top");
        step(2'b01, 64'h0, 1'b0, 64'h0, 64'h4, "wrap_inc");

        step(2'b10, 64'h103, 1'b0, 64'h103, 64'h107, "load_misaligned");
        step(2'b11, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 64'h3, 64'h7, "rel_back_big");
        step(2'b00, 64'hABCD, 1'b0, 64'h3, 64'h7, "hold_misaligned");

        @(negedge clk);
        PS = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
